// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl
// Purpose  : Run-time programmable integer clock-divider controller. Produces
//            a divided clock-enable waveform (div_out) and a one-cycle tick in
//            the last cycle of every period. New divisors arrive over a
//            valid/ready handshake and are applied only at period boundaries,
//            so the waveform never shows a runt or stretched pulse. Start and
//            stop requests are also honoured only at period ends.
//
// Parameters:
//   CNT_W      width of divisor and period counter (legal divisors 2..2^CNT_W-1)
//   DEF_DIV    divisor loaded at reset (must be 2..2^CNT_W-1)
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   rst          in   synchronous active-high reset
//   en           in   run request, level sensitive
//   cfg_valid    in   new divisor offered
//   cfg_div      in   offered divisor, sampled when cfg_valid && cfg_ready
//   cfg_ready    out  controller can accept a divisor
//   cfg_err      out  one-cycle pulse: offered divisor was < 2 and rejected
//   div_out      out  divided waveform, high for floor(N/2) of N cycles
//   tick         out  one-cycle pulse in the last cycle of each period
//   active_div   out  divisor currently in use
//   busy         out  high while running or finishing the final period
//   period_cnt   out  [15:0] completed-period counter (optional, see below)
//
// Optional feature:
//   CLK_DIV_CTRL_PERIOD_CNT_EN - when defined, adds the period_cnt output,
//   a 16-bit counter bumped once per tick, wrapping 65535 -> 0, cleared only
//   by rst and held while idle.
//
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             tick,
  output logic [CNT_W-1:0] active_div,
  output logic             busy
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] c_def_div = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] c_min_div = CNT_W'(2);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_zero    = '0;

  // --------------------------------------------------------------------------
  // State encoding
  //   S_IDLE : waveform parked low, counter held at zero
  //   S_RUN  : counting periods with en high
  //   S_STOP : en dropped; finishing the current period before going idle
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_e;

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [CNT_W-1:0] active_div_q, active_div_d;
  logic [CNT_W-1:0] pend_div_q,   pend_div_d;
  logic             pend_q,       pend_d;
  logic             cfg_ready_q,  cfg_ready_d;
  logic             cfg_err_q,    cfg_err_d;
  logic             div_out_q,    div_out_d;
  logic             tick_q,       tick_d;
  logic             busy_q,       busy_d;

  logic             w_cfg_fire;
  logic             w_cfg_bad;
  logic             w_wrap;
  logic             w_apply;
  logic [CNT_W-1:0] w_last;

  // --------------------------------------------------------------------------
  // Handshake and period-boundary detection
  // --------------------------------------------------------------------------
  assign w_cfg_fire = cfg_valid && cfg_ready_q;
  assign w_cfg_bad  = (cfg_div < c_min_div);

  // active_div is never below 2, so N-1 cannot underflow.
  assign w_last = active_div_q - c_one;
  assign w_wrap = (state_q != S_IDLE) && (cnt_q == w_last);

  // A pending divisor must already be held during the cycle that ends with
  // the wrap edge; one accepted on that very edge waits a further period.
  // While idle there is no period to protect, so it applies immediately.
  assign w_apply = pend_q && ((state_q == S_IDLE) || w_wrap);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_div_d   = pend_div_q;
    cfg_ready_d  = cfg_ready_q;
    cfg_err_d    = 1'b0;
    active_div_d = w_apply ? pend_div_q : active_div_q;

    // Apply and accept are mutually exclusive: accepting needs cfg_ready,
    // which is low whenever something is pending.
    if (w_apply) begin
      pend_d      = 1'b0;
      cfg_ready_d = 1'b1;
    end

    if (w_cfg_fire) begin
      if (w_cfg_bad) begin
        cfg_err_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_div_d  = cfg_div;
        cfg_ready_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!en) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Re-raising en cancels the stop without touching the counter.
        if (en) begin
          state_d = S_RUN;
        end else if (w_wrap) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_q == S_IDLE) || (state_d == S_IDLE) || w_wrap) begin
      cnt_d = c_zero;
    end else begin
      cnt_d = cnt_q + c_one;
    end

    // Outputs are registered from the next count and next divisor so they
    // line up with the cycle in which the counter holds that value.
    busy_d    = (state_d != S_IDLE);
    div_out_d = busy_d && (cnt_d < (active_div_d >> 1));
    tick_d    = busy_d && (cnt_d == (active_div_d - c_one));
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= c_zero;
      active_div_q <= c_def_div;
      pend_q       <= 1'b0;
      pend_div_q   <= c_zero;
      cfg_ready_q  <= 1'b1;
      cfg_err_q    <= 1'b0;
      div_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_div_q <= active_div_d;
      pend_q       <= pend_d;
      pend_div_q   <= pend_div_d;
      cfg_ready_q  <= cfg_ready_d;
      cfg_err_q    <= cfg_err_d;
      div_out_q    <= div_out_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign cfg_err    = cfg_err_q;
  assign div_out    = div_out_q;
  assign tick       = tick_q;
  assign active_div = active_div_q;
  assign busy       = busy_q;

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  // --------------------------------------------------------------------------
  // Completed-period counter: bumps at the edge closing each tick cycle and
  // wraps naturally at 16 bits. Only rst clears it, so it survives idle.
  // --------------------------------------------------------------------------
  logic [15:0] period_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt_q <= 16'd0;
    end else if (tick_q) begin
      period_cnt_q <= period_cnt_q + 16'd1;
    end
  end

  assign period_cnt = period_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_ctrl
// Purpose  : Self-checking bench for clk_div_ctrl. A period-level reference
//            model tracks "running / finishing / position within period /
//            divisor in use / divisor waiting" and pushes the expected
//            outputs for each cycle into a queue; a monitor pops one entry
//            per cycle and compares against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             div_out;
  logic             tick;
  logic [CNT_W-1:0] active_div;
  logic             busy;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0]      period_cnt;
`endif

  clk_div_ctrl #(
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .div_out    (div_out),
    .tick       (tick),
    .active_div (active_div),
    .busy       (busy)
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       div_out;
    logic       tick;
    logic [7:0] active;
    logic       ready;
    logic       err;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // --------------------------------------------------------------------------
  // Reference model (period level). Inputs are stable across each posedge
  // because stimulus only changes on the falling edge.
  // --------------------------------------------------------------------------
  bit m_on;        // producing periods
  bit m_finishing; // en was seen low; last period in progress
  int m_k;         // position inside the current period
  int m_n;         // divisor in use
  int m_pend;      // waiting divisor, 0 = none
  bit m_ready;
  bit m_err;

  always @(posedge clk) begin : model
    exp_t e;
    bit   accepted;
    bit   period_end;
    bit   take_pend;
    if (rst) begin
      m_on = 0; m_finishing = 0; m_k = 0; m_n = DEF_DIV;
      m_pend = 0; m_ready = 1; m_err = 0;
    end else begin
      accepted   = cfg_valid && m_ready;
      period_end = m_on && (m_k == m_n - 1);
      take_pend  = (m_pend != 0) && (!m_on || period_end);
      m_err      = accepted && (int'(cfg_div) < 2);

      if (!m_on) begin
        m_k = 0;
        if (en) begin
          m_on = 1;
          m_finishing = 0;
        end
      end else if (period_end) begin
        m_k = 0;
        if (m_finishing && !en) begin
          m_on = 0;
          m_finishing = 0;
        end else begin
          m_finishing = !en;
        end
      end else begin
        m_k = m_k + 1;
        m_finishing = !en;
      end

      if (take_pend) begin
        m_n = m_pend;
        m_pend = 0;
        m_ready = 1;
      end
      if (accepted && int'(cfg_div) >= 2) begin
        m_pend = int'(cfg_div);
        m_ready = 0;
      end
    end
    e.div_out = m_on && (m_k < m_n / 2);
    e.tick    = m_on && (m_k == m_n - 1);
    e.active  = 8'(m_n);
    e.ready   = m_ready;
    e.err     = m_err;
    e.busy    = m_on;
    exp_q.push_back(e);
  end

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("div_out",    32'(div_out),    32'(e.div_out));
      chk("tick",       32'(tick),       32'(e.tick));
      chk("active_div", 32'(active_div), 32'(e.active));
      chk("cfg_ready",  32'(cfg_ready),  32'(e.ready));
      chk("cfg_err",    32'(cfg_err),    32'(e.err));
      chk("busy",       32'(busy),       32'(e.busy));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic step(input logic r, input logic e, input logic v, input logic [7:0] d);
    @(negedge clk);
    rst       = r;
    en        = e;
    cfg_valid = v;
    cfg_div   = d;
  endtask

  initial begin : stim
    logic cur_en;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Default divisor run, then a divisor change mid-run.
    repeat (9) step(0, 1, 0, 0);
    step(0, 1, 1, 8'd4);
    repeat (12) step(0, 1, 0, 0);

    // Rejected divisor.
    step(0, 1, 1, 8'd1);
    repeat (3) step(0, 1, 0, 0);
    step(0, 1, 1, 8'd0);
    repeat (3) step(0, 1, 0, 0);

    // Move to N=5, then stop after a partial period.
    step(0, 1, 1, 8'd5);
    repeat (15) step(0, 1, 0, 0);
    repeat (8) step(0, 0, 0, 0);

    // Restart, drop en briefly and re-raise it before the wrap.
    repeat (7) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    repeat (10) step(0, 1, 0, 0);

    // Change divisor while idle.
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 1, 8'd2);
    repeat (3) step(0, 0, 0, 0);
    repeat (8) step(0, 1, 0, 0);

    // Reset with a divisor pending.
    step(0, 1, 1, 8'd7);
    step(1, 1, 0, 0);
    repeat (6) step(0, 1, 0, 0);

    // Largest legal divisor, then stop together with a pending change.
    step(0, 1, 1, 8'd255);
    repeat (560) step(0, 1, 0, 0);
    step(0, 1, 1, 8'd6);
    repeat (300) step(0, 0, 0, 0);

    // Randomized phase.
    cur_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic       r;
      logic       v;
      logic [7:0] d;
      if ($urandom_range(0, 19) == 0) cur_en = ~cur_en;
      r = ($urandom_range(0, 599) == 0);
      v = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: d = 8'($urandom_range(0, 9));
        5, 6, 7, 8:    d = 8'($urandom_range(2, 20));
        default:       d = 8'($urandom_range(0, 255));
      endcase
      step(r, cur_en, v, d);
    end

    step(0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
